// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential 16-bit binary to 4-digit packed BCD converter using the
//   shift-add-3 (double-dabble) method. One conversion takes 16 shift edges
//   plus one result edge. A fifth scratch digit catches values above 9999,
//   which raise overflow while bcd keeps the low four digits.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   start     in   1   conversion request, honoured only while idle
//   bin       in  16   unsigned value captured on the accepting edge
//   busy      out  1   conversion in progress
//   done      out  1   one-cycle pulse, bcd/overflow just updated
//   bcd       out 16   packed BCD, [15:12]=thousands .. [3:0]=units
//   overflow  out  1   last converted value was above 9999
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int UUID = 0,
    parameter     NAME = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        overflow
);

    // UUID and NAME only label the instance; this block elaborates to nothing.
    if ((UUID < 32'sd0) && ($bits(NAME) == 32'sd0)) begin : g_label_only
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] shift_q;
    logic [19:0] scratch_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] bcd_q;
    logic        overflow_q;

    logic [15:0] shift_d;
    logic [19:0] scratch_d;

    // Add 3 to every BCD digit that is 5 or more, so the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [19:0] add3_digits(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int d = 0; d < 5; d++) begin
            if (s[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = s[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = s[4*d +: 4];
            end
        end
        return r;
    endfunction

    // One double-dabble step: adjust digits, then shift {scratch, shift} left.
    // The digit adjust never sets scratch bit 19 for a 16-bit input, so the
    // bit shifted out of the top is always zero and is dropped by the cast.
    always_comb begin
        scratch_d = 20'({add3_digits(scratch_q), shift_q[15]});
        shift_d   = {shift_q[14:0], 1'b0};
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= 16'd0;
            scratch_q  <= 20'd0;
            cnt_q      <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 16'd0;
            overflow_q <= 1'b0;
        end else begin
            // done is a pulse: cleared on every edge that does not set it
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q   <= bin;
                        scratch_q <= 20'd0;
                        cnt_q     <= 4'd0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shift_q   <= shift_d;
                    scratch_q <= scratch_d;
                    cnt_q     <= cnt_q + 4'd1;
                    // the 16th shift edge is the one that sees cnt_q == 15
                    if (cnt_q == 4'd15) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    bcd_q      <= scratch_q[15:0];
                    overflow_q <= (scratch_q[19:16] != 4'd0);
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq. A cycle model tracks edges since
//   the accepting edge and derives expected digits with decimal arithmetic;
//   every cycle busy/done/bcd/overflow are compared against it. A vector
//   table, hand sequences for the multi-cycle corners and a random phase
//   drive the stimulus.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    bin_to_bcd_seq #(.UUID(7), .NAME("dut")) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model state
    int          m_age = -1;      // edges since acceptance, -1 when idle
    logic [15:0] m_val = 16'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_bcd  = 16'd0;
    logic        m_ovf  = 1'b0;

    function automatic logic [15:0] to_bcd(input logic [15:0] b);
        int v;
        v = int'(b) % 10000;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // Advance the model by one clock edge with the inputs sampled at it.
    task automatic model_edge(input logic r, input logic s, input logic [15:0] b);
        m_done = 1'b0;
        if (r) begin
            m_age  = -1;
            m_busy = 1'b0;
            m_bcd  = 16'd0;
            m_ovf  = 1'b0;
        end else if (m_age < 0) begin
            if (s) begin
                m_age  = 0;
                m_val  = b;
                m_busy = 1'b1;
            end
        end else begin
            m_age++;
            if (m_age == 17) begin
                m_done = 1'b1;
                m_bcd  = to_bcd(m_val);
                m_ovf  = (m_val > 16'd9999);
                m_busy = 1'b0;
                m_age  = -1;
            end
        end
    endtask

    // Apply inputs, clock once, update the model and compare all outputs.
    task automatic tick(input logic r, input logic s, input logic [15:0] b);
        rst   = r;
        start = s;
        bin   = b;
        @(posedge clk);
        model_edge(r, s, b);
        cyc++;
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("bcd", {16'd0, bcd}, {16'd0, m_bcd});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    // Start one conversion and wait (bounded) for done; reports latency/result.
    task automatic convert(input logic [15:0] b, output int lat, output logic [15:0] got_bcd,
                           output logic got_ovf);
        lat = -1;
        got_bcd = 16'd0;
        got_ovf = 1'b0;
        tick(1'b0, 1'b1, b);
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, 1'b0, 16'($urandom));
            if (done && lat < 0) begin
                lat     = k;
                got_bcd = bcd;
                got_ovf = overflow;
            end
        end
    endtask

    typedef struct {
        logic [15:0] bin;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          lat;
        logic [15:0] gb;
        logic        go;
        int          n_done;
        int          last_done;
        int          n_idle;

        vecs[0]  = '{16'd0,     16'h0000, 1'b0};
        vecs[1]  = '{16'd1234,  16'h1234, 1'b0};
        vecs[2]  = '{16'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{16'd10000, 16'h0000, 1'b1};
        vecs[4]  = '{16'd65535, 16'h5535, 1'b1};
        vecs[5]  = '{16'd9,     16'h0009, 1'b0};
        vecs[6]  = '{16'd10,    16'h0010, 1'b0};
        vecs[7]  = '{16'd99,    16'h0099, 1'b0};
        vecs[8]  = '{16'd100,   16'h0100, 1'b0};
        vecs[9]  = '{16'd1000,  16'h1000, 1'b0};
        vecs[10] = '{16'd5555,  16'h5555, 1'b0};
        vecs[11] = '{16'd12345, 16'h2345, 1'b1};

        rst = 1'b1; start = 1'b0; bin = 16'd0;

        // reset state; start held high during reset must be ignored
        tick(1'b1, 1'b1, 16'd77);
        tick(1'b1, 1'b0, 16'd0);

        // table-driven conversions
        foreach (vecs[i]) begin
            convert(vecs[i].bin, lat, gb, go);
            check("latency", 32'(lat), 32'd17);
            check("tbl_bcd", {16'd0, gb}, {16'd0, vecs[i].exp_bcd});
            check("tbl_ovf", {31'd0, go}, {31'd0, vecs[i].exp_ovf});
        end

        // start ignored while busy, bin toggling every cycle
        n_done = 0;
        tick(1'b0, 1'b1, 16'd42);
        for (int c = 1; c <= 25; c++) begin
            if (c == 5) tick(1'b0, 1'b1, 16'd7);
            else        tick(1'b0, 1'b0, 16'($urandom));
            if (done) begin
                n_done++;
                check("ignore_bcd", {16'd0, bcd}, 32'h0000_0042);
            end
        end
        check("ignore_ndone", 32'(n_done), 32'd1);

        // start ignored in the DONE cycle (edge 17), accepted one edge later
        tick(1'b0, 1'b1, 16'd11);
        for (int c = 1; c <= 16; c++) tick(1'b0, 1'b0, 16'd0);
        tick(1'b0, 1'b1, 16'd22);
        check("done_cycle_busy", {31'd0, busy}, 32'd0);
        for (int c = 1; c <= 20; c++) tick(1'b0, 1'b0, 16'd0);
        check("done_cycle_bcd", {16'd0, bcd}, 32'h0000_0011);

        // reset abandons a conversion; start accepted on first edge after reset
        tick(1'b0, 1'b1, 16'd500);
        for (int c = 1; c <= 7; c++) tick(1'b0, 1'b0, 16'd500);
        tick(1'b1, 1'b0, 16'd500);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bcd", {16'd0, bcd}, 32'd0);
        n_done = 0;
        lat = -1;
        tick(1'b0, 1'b1, 16'd321);
        for (int k = 1; k <= 30; k++) begin
            tick(1'b0, 1'b0, 16'($urandom));
            if (done) begin
                n_done++;
                lat = k;
                check("rst_new_bcd", {16'd0, bcd}, 32'h0000_0321);
            end
        end
        check("rst_ndone", 32'(n_done), 32'd1);
        check("rst_new_lat", 32'(lat), 32'd17);

        // continuous start: back-to-back conversions every 18 cycles
        n_done = 0;
        last_done = -1;
        n_idle = 0;
        for (int c = 0; c < 80; c++) begin
            tick(1'b0, 1'b1, 16'd88);
            if (!busy) n_idle++;
            if (done) begin
                check("b2b_bcd", {16'd0, bcd}, 32'h0000_0088);
                if (last_done >= 0) check("b2b_period", 32'(cyc - last_done), 32'd18);
                last_done = cyc;
                n_done++;
            end
        end
        check("b2b_ndone", 32'(n_done), 32'd4);
        check("b2b_idle", 32'(n_idle), 32'd4);
        tick(1'b1, 1'b0, 16'd0);

        // randomized phase, checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            logic        r;
            logic        s;
            logic [15:0] b;
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(9990, 10010));
                1:       b = 16'($urandom_range(0, 20));
                default: b = 16'($urandom);
            endcase
            tick(r, s, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
